// File: rtl/sev_seg_scan_if.sv
// sev_seg_scan_if
// Bundles the display request and status signals of sev_seg_scan.
//   value      : unsigned binary number to display (VAL_W bits)
//   load       : single-cycle capture request
//   blank_lead : suppress leading-zero digits when high
//   busy       : conversion in progress
//   ovf        : last captured value exceeded 9999
//   LED_BCD    : BCD value of the currently scanned digit
//   anode      : active-low one-hot digit enables (bit0 = ones)
// master = the producer of requests, slave = the scanner itself.
interface sev_seg_scan_if #(
  parameter int VAL_W = 14
);
  logic [VAL_W-1:0] value;
  logic             load;
  logic             blank_lead;
  logic             busy;
  logic             ovf;
  logic [3:0]       LED_BCD;
  logic [3:0]       anode;

  modport master (
    output value, load, blank_lead,
    input  busy, ovf, LED_BCD, anode
  );

  modport slave (
    input  value, load, blank_lead,
    output busy, ovf, LED_BCD, anode
  );
endinterface

// File: rtl/sev_seg_scan.sv
// sev_seg_scan
// Captures a binary value, converts it to four BCD digits with a sequential
// shift-add-3 (double dabble) converter, and time-multiplexes the digits onto
// a 4-digit common-anode 7-segment display.
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : sev_seg_scan_if.slave (value/load/blank_lead in,
//          busy/ovf/LED_BCD/anode out)
// Parameters:
//   REFRESH_DIV : clock cycles each digit stays lit (2..2^20)
//   VAL_W       : width of the binary input value (at least 14)
module sev_seg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int VAL_W       = 14
) (
  input logic          clk,
  input logic          rst,
  sev_seg_scan_if.slave bus
);

  localparam int CNT_W  = $clog2(VAL_W + 1);
  localparam int RCNT_W = $clog2(REFRESH_DIV);
  localparam int MAX_DISPLAY = 9999;

  typedef enum logic {
    IDLE,
    CONV
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  shiftCnt_q, shiftCnt_d;
  logic [VAL_W-1:0]  bin_q, bin_d;
  // Partial BCD result. Every intermediate value is at most 4999, so the
  // thousands nibble never exceeds 4 before a shift and fits in 3 bits here;
  // only the final shift produces a full 4-bit thousands digit.
  logic [14:0]       bcd_q, bcd_d;
  logic [14:0]       bcdAdj;
  logic [15:0]       bcdShift;
  logic [15:0]       digits_q, digits_d;
  logic              ovf_q, ovf_d;
  logic [RCNT_W-1:0] refresh_q, refresh_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        led_q, led_d;
  logic [3:0]        anode_q, anode_d;

  logic busyC;
  logic lastShift;
  logic capture;
  logic overRange;
  logic refreshWrap;
  logic zero3, zero2, zero1;
  logic blankSel;

  assign capture   = bus.load && (state_q == IDLE);
  assign lastShift = (state_q == CONV) && (shiftCnt_q == CNT_W'(VAL_W - 1));
  assign overRange = (32'(bus.value) > 32'(MAX_DISPLAY));

  // State register; reset abandons any conversion in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a load starts a conversion only while idle, and the
  // conversion ends on its VAL_W-th shift.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.load) state_d = CONV;
      CONV:    if (lastShift) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busyC = 1'b0;
    if (state_q == CONV) busyC = 1'b1;
  end

  // Add 3 to every BCD nibble that is 5 or more before it gets shifted.
  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcdShift = {bcdAdj, bin_q[VAL_W-1]};
  end

  // Converter datapath: capture with saturation at 9999, then one shift per
  // cycle. The displayed digits take the final shift result directly so the
  // display changes on the same edge busy falls.
  always_comb begin
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    shiftCnt_d = shiftCnt_q;
    ovf_d      = ovf_q;
    digits_d   = digits_q;
    if (capture) begin
      bin_d      = overRange ? VAL_W'(MAX_DISPLAY) : bus.value;
      bcd_d      = '0;
      shiftCnt_d = '0;
      ovf_d      = overRange;
    end else if (state_q == CONV) begin
      bin_d      = bin_q << 1;
      bcd_d      = bcdShift[14:0];
      shiftCnt_d = shiftCnt_q + 1'b1;
      if (lastShift) digits_d = bcdShift;
    end
  end

  // Scan logic: free-running refresh counter advancing the digit index.
  // LED_BCD and anode are registered from the next-state index and digits so
  // they move on the same edge as the index or the digits.
  always_comb begin
    refreshWrap = (refresh_q == RCNT_W'(REFRESH_DIV - 1));
    refresh_d   = refreshWrap ? '0 : refresh_q + 1'b1;
    idx_d       = refreshWrap ? idx_q + 2'd1 : idx_q;
    led_d       = digits_d[{idx_d, 2'b00} +: 4];

    // A digit is a leading zero when it and every higher digit are zero;
    // the ones digit is never blanked.
    zero3 = (digits_d[15:12] == 4'd0);
    zero2 = zero3 && (digits_d[11:8] == 4'd0);
    zero1 = zero2 && (digits_d[7:4] == 4'd0);
    case (idx_d)
      2'd1:    blankSel = zero1;
      2'd2:    blankSel = zero2;
      2'd3:    blankSel = zero3;
      default: blankSel = 1'b0;
    endcase
    anode_d = (bus.blank_lead && blankSel) ? 4'b1111 : ~(4'b0001 << idx_d);
  end

  // Datapath and display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      shiftCnt_q <= '0;
      ovf_q      <= 1'b0;
      digits_q   <= '0;
      refresh_q  <= '0;
      idx_q      <= 2'd0;
      led_q      <= 4'h0;
      anode_q    <= 4'b1110;
    end else begin
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      shiftCnt_q <= shiftCnt_d;
      ovf_q      <= ovf_d;
      digits_q   <= digits_d;
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      led_q      <= led_d;
      anode_q    <= anode_d;
    end
  end

  assign bus.busy    = busyC;
  assign bus.ovf     = ovf_q;
  assign bus.LED_BCD = led_q;
  assign bus.anode   = anode_q;

endmodule

// File: tb/tb_sev_seg_scan.sv
// tb_sev_seg_scan
// Self-checking bench for sev_seg_scan with a short refresh period.
// A behavioural model (integer arithmetic on the displayed number) is checked
// against the outputs every cycle; table-driven vectors and hand-written
// sequences cover conversion length, saturation, blanking, ignored loads,
// back-to-back loads and reset during conversion.
module tb_sev_seg_scan;

  localparam int REFRESH_DIV = 4;
  localparam int VAL_W       = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sev_seg_scan_if #(.VAL_W(VAL_W)) bus();

  sev_seg_scan #(
    .REFRESH_DIV(REFRESH_DIV),
    .VAL_W(VAL_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;

  typedef struct {
    int          value;
    bit          blank;
    bit          expOvf;
    logic [15:0] expBcd;
  } vec_t;

  vec_t vecs[9];

  // Reference model state: edges since reset, remaining busy cycles,
  // number currently on the display and the pending converted number.
  int mN       = 0;
  int mBusyCnt = 0;
  int mShown   = 0;
  int mPending = 0;
  bit mOvf     = 1'b0;
  bit mBlank   = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  function automatic int pow10(input int i);
    case (i)
      0:       return 1;
      1:       return 10;
      2:       return 100;
      default: return 1000;
    endcase
  endfunction

  function automatic int modelAnode(input int shown, input int idx, input bit blank);
    if (blank && idx != 0 && shown < pow10(idx)) return 15;
    return (~(1 << idx)) & 15;
  endfunction

  // Behavioural model, advanced on every rising edge.
  always @(posedge clk) begin
    if (rst) begin
      mN       <= 0;
      mBusyCnt <= 0;
      mShown   <= 0;
      mPending <= 0;
      mOvf     <= 1'b0;
      mBlank   <= bus.blank_lead;
    end else begin
      mN     <= mN + 1;
      mBlank <= bus.blank_lead;
      if (mBusyCnt == 0) begin
        if (bus.load) begin
          mPending <= (int'(bus.value) > 9999) ? 9999 : int'(bus.value);
          mOvf     <= (int'(bus.value) > 9999);
          mBusyCnt <= VAL_W;
        end
      end else begin
        mBusyCnt <= mBusyCnt - 1;
        if (mBusyCnt == 1) mShown <= mPending;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      automatic int idx = (mN / REFRESH_DIV) % 4;
      checkOutput("model_busy", int'(bus.busy), int'(mBusyCnt != 0));
      checkOutput("model_ovf", int'(bus.ovf), int'(mOvf));
      checkOutput("model_led", int'(bus.LED_BCD), (mShown / pow10(idx)) % 10);
      checkOutput("model_anode", int'(bus.anode), modelAnode(mShown, idx, mBlank));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse load for one edge with the given value and blanking mode.
  task automatic applyStimulus(input int value, input bit blank);
    bus.value      = VAL_W'(value);
    bus.blank_lead = blank;
    bus.load       = 1'b1;
    step(1);
    bus.load       = 1'b0;
  endtask

  // Scan all four digit slots and compare against an expected BCD word.
  task automatic scanCheck(input logic [15:0] expBcd, input bit blank, input string tag);
    for (int c = 0; c < 4 * REFRESH_DIV; c++) begin
      automatic int idx = (mN / REFRESH_DIV) % 4;
      automatic logic [15:0] upper = expBcd >> (idx * 4);
      automatic int expAn = (blank && idx != 0 && upper == 16'd0) ? 15 : ((~(1 << idx)) & 15);
      checkOutput({tag, "_led"}, int'(bus.LED_BCD), int'(upper[3:0]));
      checkOutput({tag, "_anode"}, int'(bus.anode), expAn);
      step(1);
    end
  endtask

  initial begin
    int busyLen;

    vecs[0] = '{1234,  1'b0, 1'b0, 16'h1234};
    vecs[1] = '{16383, 1'b0, 1'b1, 16'h9999};
    vecs[2] = '{0,     1'b0, 1'b0, 16'h0000};
    vecs[3] = '{7,     1'b1, 1'b0, 16'h0007};
    vecs[4] = '{1000,  1'b1, 1'b0, 16'h1000};
    vecs[5] = '{9999,  1'b1, 1'b0, 16'h9999};
    vecs[6] = '{10000, 1'b0, 1'b1, 16'h9999};
    vecs[7] = '{305,   1'b1, 1'b0, 16'h0305};
    vecs[8] = '{0,     1'b1, 1'b0, 16'h0000};

    bus.value      = '0;
    bus.load       = 1'b0;
    bus.blank_lead = 1'b0;
    rst            = 1'b1;
    step(2);
    rst     = 1'b0;
    checkEn = 1'b1;

    // Reset state, then an idle scan with all digits zero.
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_ovf", int'(bus.ovf), 0);
    checkOutput("reset_led", int'(bus.LED_BCD), 0);
    checkOutput("reset_anode", int'(bus.anode), 14);
    // Align to the start of slot 0 so the scan covers four full slots.
    step(4 * REFRESH_DIV - 1);
    scanCheck(16'h0000, 1'b0, "idle");

    // Table-driven conversions.
    foreach (vecs[v]) begin
      applyStimulus(vecs[v].value, vecs[v].blank);
      busyLen = 0;
      for (int i = 0; i < 20; i++) begin
        if (bus.busy) busyLen++;
        step(1);
      end
      checkOutput($sformatf("vec%0d_busyLen", v), busyLen, VAL_W);
      checkOutput($sformatf("vec%0d_ovf", v), int'(bus.ovf), int'(vecs[v].expOvf));
      scanCheck(vecs[v].expBcd, vecs[v].blank, $sformatf("vec%0d", v));
    end

    // Load while busy is ignored.
    applyStimulus(5678, 1'b0);
    step(3);
    applyStimulus(42, 1'b0);
    step(20);
    scanCheck(16'h5678, 1'b0, "ignoredLoad");

    // Back-to-back: a load in the first idle cycle is accepted.
    applyStimulus(1111, 1'b0);
    step(VAL_W - 1);
    checkOutput("b2b_lastBusy", int'(bus.busy), 1);
    step(1);
    checkOutput("b2b_idle", int'(bus.busy), 0);
    applyStimulus(42, 1'b0);
    checkOutput("b2b_busy", int'(bus.busy), 1);
    step(20);
    scanCheck(16'h0042, 1'b0, "b2b");

    // Reset in the middle of converting 9999.
    applyStimulus(9999, 1'b0);
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("midRst_busy", int'(bus.busy), 0);
    checkOutput("midRst_anode", int'(bus.anode), 14);
    checkOutput("midRst_led", int'(bus.LED_BCD), 0);
    checkOutput("midRst_ovf", int'(bus.ovf), 0);
    step(4 * REFRESH_DIV * 2 - 1);
    scanCheck(16'h0000, 1'b0, "midRst");

    // Randomized loads, blanking changes and load timing.
    for (int r = 0; r < 60; r++) begin
      applyStimulus(int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 25)) begin
        if ($urandom_range(0, 7) == 0) bus.blank_lead = ~bus.blank_lead;
        step(1);
      end
    end
    step(20);

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sev_seg_scan.md
SEV_SEG_SCAN -- requirements
Module: sev_seg_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is held active (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter VAL_W, default 14, width of the binary input value.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port value  input  VAL_W  unsigned binary number to display.
REQ-006 SHALL have port load  input  1  single-cycle request to capture value and convert.
REQ-007 SHALL have port blank_lead  input  1  when high, suppress leading-zero digits.
REQ-008 SHALL have port busy  output  1  conversion in progress; high while a load is being processed.
REQ-009 SHALL have port ovf  output  1  last captured value exceeded 9999.
REQ-010 SHALL have port LED_BCD  output  4  BCD value of the currently scanned digit, for the downstream 7-segment decoder.
REQ-011 SHALL have port anode  output  4  digit enables, active-low, one-hot; bit0 = ones digit, bit3 = thousands.

Function
REQ-012 SHALL capture value on the edge where load=1 and busy=0; if value>9999, SHALL substitute 9999 and set ovf=1, else clear ovf, ovf updated on this same edge.
REQ-013 SHALL ignore load while busy=1: no capture, no restart, no ovf change.
REQ-014 SHALL convert with sequential shift-add-3 (double dabble): one shift per cycle, VAL_W shifts total; each BCD nibble >=5 gets +3 before each shift.
REQ-015 SHALL assert busy from the cycle after capture for exactly VAL_W cycles (14 by default), then deassert.
REQ-016 SHALL update all four displayed digit registers atomically on the edge busy falls; display SHALL show the previous result unchanged throughout conversion.
REQ-017 SHALL accept a new load in the first cycle busy=0 after completion (back-to-back loads: 15-cycle spacing at default VAL_W).
REQ-018 SHALL run a refresh counter 0..REFRESH_DIV-1 continuously, independent of busy; on wrap, digit index SHALL advance 0->1->2->3->0.
REQ-019 SHALL drive LED_BCD = stored digit[index] and anode = ~(1<<index), both registered, changing on the same edge as index.
REQ-020 SHALL, when blank_lead=1, drive anode=4'b1111 for index 3, 2, 1 whose digit and all higher digits are zero; ones digit (index 0) SHALL never be blanked; LED_BCD unaffected.
REQ-021 SHALL apply blank_lead combinationally to the anode register input (effect at next refresh edge of the affected digit or sooner if the current digit changes blanking status, within one cycle).
REQ-022 SHALL never assert more than one anode bit low in any cycle.

Reset
REQ-023 SHALL on rst=1 set refresh counter 0, index 0, all digits 0, busy 0, ovf 0, anode 4'b1110, LED_BCD 4'h0, abandoning any conversion in progress.
REQ-024 SHALL ignore load in any cycle rst=1; rst SHALL override all other inputs.

Verification
REQ-025 SHALL cover: REFRESH_DIV=4, reset, no load -> anode cycles 1110,1101,1011,0111 each 4 cycles, LED_BCD=0 throughout.
REQ-026 SHALL cover: load value=1234 -> busy high exactly 14 cycles, then LED_BCD 4,3,2,1 with anodes 1110,1101,1011,0111; ovf=0.
REQ-027 SHALL cover: load value=16383 -> ovf=1, digits 9,9,9,9; then load 0 -> ovf=0, digits 0.
REQ-028 SHALL cover: blank_lead=1, value=7 -> anode 1110 with LED_BCD 7, other slots anode 1111; value=1000 -> no blanking.
REQ-029 SHALL cover: load 5678 then load 42 during busy -> 42 ignored, display 5678; load 42 after busy falls -> display 0042.
REQ-030 SHALL cover: rst asserted mid-conversion of 9999 -> next cycle busy=0, digits 0, anode 1110; no later completion update.
